// File: rtl/pkt_arb_avlstrm_pkg.sv
// Shared types and helpers for the Avalon-ST packet arbiter.
// Holds the arbiter state enum, counter width and saturating-count helpers.
package pkt_arb_avlstrm_pkg;

  localparam int unsigned CntW  = 32;
  localparam int unsigned MaxIn = 8;

  typedef enum logic [0:0] {
    StIdle,
    StXfer
  } arb_state_e;

  function automatic logic [3:0] popcount8(input logic [MaxIn-1:0] vec);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < int'(MaxIn); i++) begin
      n = n + {3'b000, vec[i]};
    end
    return n;
  endfunction

  function automatic logic [CntW-1:0] sat_add(input logic [CntW-1:0] a, input logic [3:0] b);
    logic [CntW:0] s;
    s = {1'b0, a} + {{(CntW - 3){1'b0}}, b};
    return s[CntW] ? '1 : s[CntW-1:0];
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after (last + 1) mod NUM_IN.
module rr_pick #(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned IDX_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  last,
  output logic              valid,
  output logic [IDX_W-1:0]  idx
);

  int unsigned      pos;
  logic [IDX_W-1:0] pos_idx;

  always_comb begin
    valid   = 1'b0;
    idx     = last;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned k = 1; k <= NUM_IN; k++) begin
      pos     = (32'(last) + k) % NUM_IN;
      pos_idx = IDX_W'(pos);
      if (!valid && req[pos_idx]) begin
        valid = 1'b1;
        idx   = pos_idx;
      end
    end
  end

endmodule

// File: rtl/pkt_arb_avlstrm.sv
// Packet-granular round-robin arbiter merging NUM_IN Avalon-ST sources into one stream.
// Optional per-requester packet counters are enabled with the PKT_ARB_STATS_EN macro.
module pkt_arb_avlstrm
  import pkt_arb_avlstrm_pkg::*;
#(
  parameter int unsigned NUM_IN  = 4,
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned EMPTY_W = 6
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_IN-1:0][DATA_W-1:0]     in_data,
  input  logic [NUM_IN-1:0]                 in_valid,
  output logic [NUM_IN-1:0]                 in_ready,
  input  logic [NUM_IN-1:0]                 in_sop,
  input  logic [NUM_IN-1:0]                 in_eop,
  input  logic [NUM_IN-1:0][EMPTY_W-1:0]    in_empty,
  output logic [DATA_W-1:0]                 out_data,
  output logic                              out_valid,
  output logic                              out_sop,
  output logic                              out_eop,
  output logic [EMPTY_W-1:0]                out_empty,
  input  logic                              out_ready,
  input  logic                              out_almost_full,
  output logic [$clog2(NUM_IN)-1:0]         cur_grant,
`ifdef PKT_ARB_STATS_EN
  output logic [NUM_IN-1:0][CntW-1:0]       pkt_cnt,
`endif
  output logic [CntW-1:0]                   drop_cnt
);

  localparam int unsigned GntW = $clog2(NUM_IN);

  arb_state_e       state_q, state_d;
  logic [GntW-1:0]  grant_q, grant_d;
  logic [CntW-1:0]  drop_cnt_q, drop_cnt_d;

  logic [NUM_IN-1:0] req;
  logic [NUM_IN-1:0] orphan;
  logic [MaxIn-1:0]  orphan_ext;
  logic              pick_valid;
  logic [GntW-1:0]   pick_idx;
  logic              eop_acc;

  assign req = in_valid & in_sop;

  rr_pick #(
    .NUM_IN(NUM_IN),
    .IDX_W (GntW)
  ) u_rr_pick (
    .req  (req),
    .last (grant_q),
    .valid(pick_valid),
    .idx  (pick_idx)
  );

  // Output mux: the granted source drives the stream only while a packet is in flight.
  always_comb begin
    out_data   = in_data[grant_q];
    out_empty  = in_empty[grant_q];
    out_valid  = 1'b0;
    out_sop    = 1'b0;
    out_eop    = 1'b0;
    orphan     = '0;
    orphan_ext = '0;
    in_ready   = '0;
    if (state_q == StXfer) begin
      out_valid         = in_valid[grant_q];
      out_sop           = in_sop[grant_q];
      out_eop           = in_eop[grant_q];
      in_ready[grant_q] = out_ready;
    end else begin
      // Beats without sop while idle can never be granted; sink them so sources resync.
      orphan   = in_valid & ~in_sop;
      in_ready = orphan;
    end
    orphan_ext[NUM_IN-1:0] = orphan;
    eop_acc = out_valid & out_ready & out_eop;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    drop_cnt_d = sat_add(drop_cnt_q, popcount8(orphan_ext));
    unique case (state_q)
      StIdle: begin
        if (!out_almost_full && pick_valid) begin
          state_d = StXfer;
          grant_d = pick_idx;
        end
      end
      StXfer: begin
        if (eop_acc) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      grant_q    <= GntW'(NUM_IN - 1);
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign cur_grant = grant_q;
  assign drop_cnt  = drop_cnt_q;

`ifdef PKT_ARB_STATS_EN
  logic [NUM_IN-1:0][CntW-1:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (eop_acc) begin
      pkt_cnt_d[grant_q] = sat_add(pkt_cnt_q[grant_q], 4'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_pkt_arb_avlstrm.sv
// Directed self-checking bench for pkt_arb_avlstrm: arbitration order, flow control,
// orphan dropping and reset behaviour; inputs change and outputs are sampled at negedge.
module tb_pkt_arb_avlstrm;

  localparam int NumIn  = 4;
  localparam int DataW  = 512;
  localparam int EmptyW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NumIn-1:0][DataW-1:0]  in_data;
  logic [NumIn-1:0]             in_valid, in_ready, in_sop, in_eop;
  logic [NumIn-1:0][EmptyW-1:0] in_empty;
  logic [DataW-1:0]             out_data;
  logic                         out_valid, out_sop, out_eop, out_ready, out_almost_full;
  logic [EmptyW-1:0]            out_empty;
  logic [1:0]                   cur_grant;
  logic [31:0]                  drop_cnt;
`ifdef PKT_ARB_STATS_EN
  logic [NumIn-1:0][31:0]       pkt_cnt;
`endif

  pkt_arb_avlstrm #(
    .NUM_IN (NumIn),
    .DATA_W (DataW),
    .EMPTY_W(EmptyW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sop         (in_sop),
    .in_eop         (in_eop),
    .in_empty       (in_empty),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_sop        (out_sop),
    .out_eop        (out_eop),
    .out_empty      (out_empty),
    .out_ready      (out_ready),
    .out_almost_full(out_almost_full),
    .cur_grant      (cur_grant),
`ifdef PKT_ARB_STATS_EN
    .pkt_cnt        (pkt_cnt),
`endif
    .drop_cnt       (drop_cnt)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int src_len[NumIn];
  int src_npkt[NumIn];
  int src_pos[NumIn];
  int src_pkt[NumIn];
  bit src_sopm[NumIn];

  logic [31:0] rx_tag[$];
  int          rx_grant[$];
  int          rx_cyc[$];
  bit          rx_sop[$];
  bit          rx_eop[$];

  function automatic logic [31:0] tag(int i, int p, int b);
    return {8'(i), 8'(p), 8'(b), 8'hA5};
  endfunction

  task automatic drive_sources();
    for (int i = 0; i < NumIn; i++) begin
      if (src_npkt[i] > 0) begin
        in_valid[i] = 1'b1;
        in_sop[i]   = src_sopm[i] && (src_pos[i] == 0);
        in_eop[i]   = src_sopm[i] && (src_pos[i] == src_len[i] - 1);
        in_data[i]  = DataW'(tag(i, src_pkt[i], src_pos[i]));
        in_empty[i] = EmptyW'(src_pos[i]);
      end else begin
        in_valid[i] = 1'b0;
        in_sop[i]   = 1'b0;
        in_eop[i]   = 1'b0;
        in_data[i]  = '0;
        in_empty[i] = '0;
      end
    end
  endtask

  task automatic set_src(int i, int len, int npkt, bit sopm);
    src_len[i]  = len;
    src_npkt[i] = npkt;
    src_pos[i]  = 0;
    src_pkt[i]  = 0;
    src_sopm[i] = sopm;
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < NumIn; i++) set_src(i, 1, 0, 1'b1);
  endtask

  function automatic bit pending();
    for (int i = 0; i < NumIn; i++) if (src_npkt[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_rx();
    rx_tag.delete();
    rx_grant.delete();
    rx_cyc.delete();
    rx_sop.delete();
    rx_eop.delete();
  endtask

  // One clock: log the output beat, advance sources that handed off a beat, return at negedge.
  task automatic step();
    logic [NumIn-1:0] acc;
    acc = rst_n ? (in_valid & in_ready) : '0;
    if (rst_n && out_valid && out_ready) begin
      rx_tag.push_back(out_data[31:0]);
      rx_grant.push_back(int'(cur_grant));
      rx_cyc.push_back(cyc);
      rx_sop.push_back(out_sop);
      rx_eop.push_back(out_eop);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NumIn; i++) begin
      if (acc[i]) begin
        src_pos[i]++;
        if (src_pos[i] == src_len[i]) begin
          src_pos[i] = 0;
          src_npkt[i]--;
          src_pkt[i]++;
        end
      end
    end
    drive_sources();
    @(negedge clk);
  endtask

  task automatic run_until_idle(int budget, string name);
    int n = 0;
    while (pending() && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (pending()) begin
      failures++;
      $display("FAIL %s_drain: sources still pending after %0d cycles, required drained", name,
               budget);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_srcs();
    drive_sources();
    out_ready = 1'b1;
    out_almost_full = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    clear_rx();
    cyc = 0;
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid: got %0b required 0", out_valid);
    end
    checks++;
    if (in_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_in_ready: got %b required 0000", in_ready);
    end
    checks++;
    if (cur_grant !== 2'd3) begin
      failures++;
      $display("FAIL reset_cur_grant: got %0d required 3", cur_grant);
    end
    checks++;
    if (drop_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_drop_cnt: got %0d required 0", drop_cnt);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_two_packets();
    logic [31:0] exp_tag[6];
    int          exp_g[6];
    int          exp_c[6];
    apply_reset();
    set_src(0, 3, 1, 1'b1);
    set_src(2, 3, 1, 1'b1);
    drive_sources();
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL two_pkt_bubble0: out_valid got %0b required 0", out_valid);
    end
    run_until_idle(40, "two_pkt");
    exp_tag = '{tag(0, 0, 0), tag(0, 0, 1), tag(0, 0, 2), tag(2, 0, 0), tag(2, 0, 1), tag(2, 0, 2)};
    exp_g   = '{0, 0, 0, 2, 2, 2};
    exp_c   = '{1, 2, 3, 5, 6, 7};
    checks++;
    if (rx_tag.size() != 6) begin
      failures++;
      $display("FAIL two_pkt_count: got %0d beats required 6", rx_tag.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (rx_tag[k] !== exp_tag[k] || rx_grant[k] != exp_g[k] || rx_cyc[k] != exp_c[k]) begin
          failures++;
          $display("FAIL two_pkt_beat%0d: got tag %h grant %0d cyc %0d required %h %0d %0d", k,
                   rx_tag[k], rx_grant[k], rx_cyc[k], exp_tag[k], exp_g[k], exp_c[k]);
        end
      end
      checks++;
      if (rx_sop[0] !== 1'b1 || rx_eop[2] !== 1'b1 || rx_sop[3] !== 1'b1 || rx_eop[5] !== 1'b1)
      begin
        failures++;
        $display("FAIL two_pkt_framing: sop0 %0b eop2 %0b sop3 %0b eop5 %0b required all 1",
                 rx_sop[0], rx_eop[2], rx_sop[3], rx_eop[5]);
      end
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < NumIn; i++) set_src(i, 1, 2, 1'b1);
    drive_sources();
    run_until_idle(60, "rr");
    checks++;
    if (rx_tag.size() != 8) begin
      failures++;
      $display("FAIL rr_count: got %0d beats required 8", rx_tag.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (rx_grant[k] != k % 4 || rx_cyc[k] != 2 * k + 1 || rx_tag[k] !== tag(k % 4, k / 4, 0))
        begin
          failures++;
          $display("FAIL rr_beat%0d: got grant %0d cyc %0d tag %h required %0d %0d %h", k,
                   rx_grant[k], rx_cyc[k], rx_tag[k], k % 4, 2 * k + 1, tag(k % 4, k / 4, 0));
        end
      end
    end
`ifdef PKT_ARB_STATS_EN
    checks++;
    if (pkt_cnt[0] !== 32'd2 || pkt_cnt[3] !== 32'd2) begin
      failures++;
      $display("FAIL rr_pkt_cnt: got %0d/%0d required 2/2", pkt_cnt[0], pkt_cnt[3]);
    end
`endif
  endtask

  task automatic test_almost_full();
    apply_reset();
    out_almost_full = 1'b1;
    set_src(1, 2, 1, 1'b1);
    drive_sources();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 4'b0000 || cur_grant !== 2'd3) begin
        failures++;
        $display("FAIL af_hold%0d: got valid %0b ready %b grant %0d required 0 0000 3", k,
                 out_valid, in_ready, cur_grant);
      end
      step();
    end
    out_almost_full = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL af_release_same: out_valid got %0b required 0", out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || cur_grant !== 2'd1 || out_data[31:0] !== tag(1, 0, 0)) begin
      failures++;
      $display("FAIL af_release_grant: got valid %0b grant %0d tag %h required 1 1 %h",
               out_valid, cur_grant, out_data[31:0], tag(1, 0, 0));
    end
    run_until_idle(20, "af");
    checks++;
    if (rx_tag.size() != 2) begin
      failures++;
      $display("FAIL af_count: got %0d beats required 2", rx_tag.size());
    end
  endtask

  task automatic test_af_mid_packet();
    apply_reset();
    set_src(0, 4, 1, 1'b1);
    drive_sources();
    step();
    out_almost_full = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready[0] !== 1'b0 || out_data[31:0] !== tag(0, 0, 1)) begin
      failures++;
      $display("FAIL afmid_stall: got valid %0b ready %0b tag %h required 1 0 %h", out_valid,
               in_ready[0], out_data[31:0], tag(0, 0, 1));
    end
    step();
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_data[31:0] !== tag(0, 0, 1) || in_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL afmid_resume: got tag %h ready %0b required %h 1", out_data[31:0],
               in_ready[0], tag(0, 0, 1));
    end
    run_until_idle(20, "afmid");
    checks++;
    if (rx_tag.size() != 4) begin
      failures++;
      $display("FAIL afmid_count: got %0d beats required 4", rx_tag.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rx_tag[k] !== tag(0, 0, k) || rx_sop[k] != (k == 0) || rx_eop[k] != (k == 3)) begin
          failures++;
          $display("FAIL afmid_beat%0d: got tag %h sop %0b eop %0b required %h %0b %0b", k,
                   rx_tag[k], rx_sop[k], rx_eop[k], tag(0, 0, k), k == 0, k == 3);
        end
      end
    end
    out_almost_full = 1'b0;
  endtask

  task automatic test_orphans();
    apply_reset();
    set_src(1, 2, 1, 1'b0);
    drive_sources();
    #1;
    checks++;
    if (in_ready !== 4'b0010 || out_valid !== 1'b0 || drop_cnt !== 32'd0) begin
      failures++;
      $display("FAIL orphan_first: got ready %b valid %0b drop %0d required 0010 0 0", in_ready,
               out_valid, drop_cnt);
    end
    step();
    checks++;
    if (drop_cnt !== 32'd1 || in_ready !== 4'b0010) begin
      failures++;
      $display("FAIL orphan_second: got drop %0d ready %b required 1 0010", drop_cnt, in_ready);
    end
    step();
    checks++;
    if (drop_cnt !== 32'd2 || in_valid !== 4'b0000) begin
      failures++;
      $display("FAIL orphan_done: got drop %0d valid %b required 2 0000", drop_cnt, in_valid);
    end
    step();
    checks++;
    if (drop_cnt !== 32'd2 || rx_tag.size() != 0) begin
      failures++;
      $display("FAIL orphan_hold: got drop %0d beats %0d required 2 0", drop_cnt, rx_tag.size());
    end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    set_src(0, 4, 1, 1'b1);
    drive_sources();
    step();
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data[31:0] !== tag(0, 0, 1)) begin
      failures++;
      $display("FAIL rstmid_beat2: got valid %0b tag %h required 1 %h", out_valid,
               out_data[31:0], tag(0, 0, 1));
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || cur_grant !== 2'd3 || drop_cnt !== 32'd0) begin
      failures++;
      $display("FAIL rstmid_async: got valid %0b grant %0d drop %0d required 0 3 0", out_valid,
               cur_grant, drop_cnt);
    end
    checks++;
    if (rx_tag.size() != 1 || rx_eop[0] !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_no_eop: got %0d beats before reset required 1 without eop",
               rx_tag.size());
    end
    set_src(0, 2, 1, 1'b1);
    set_src(1, 2, 1, 1'b1);
    drive_sources();
    step();
    rst_n = 1'b1;
    clear_rx();
    run_until_idle(30, "rstmid");
    checks++;
    if (rx_tag.size() != 4) begin
      failures++;
      $display("FAIL rstmid_count: got %0d beats required 4", rx_tag.size());
    end else begin
      checks++;
      if (rx_grant[0] != 0 || rx_tag[0] !== tag(0, 0, 0) || rx_grant[2] != 1 ||
          rx_tag[2] !== tag(1, 0, 0)) begin
        failures++;
        $display("FAIL rstmid_order: got %0d:%h %0d:%h required 0:%h 1:%h", rx_grant[0],
                 rx_tag[0], rx_grant[2], rx_tag[2], tag(0, 0, 0), tag(1, 0, 0));
      end
    end
  endtask

  initial begin
    out_ready = 1'b1;
    out_almost_full = 1'b0;
    clear_srcs();
    drive_sources();
    @(negedge clk);
    test_reset();
    test_two_packets();
    test_round_robin();
    test_almost_full();
    test_af_mid_packet();
    test_orphans();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pkt_arb_avlstrm.md
PKT_ARB_AVLSTRM -- requirements
Module: pkt_arb_avlstrm

Interface
REQ-001 Parameter NUM_IN, default 4; number of Avalon-ST packet requesters, 2..8.
REQ-002 Parameter DATA_W, default 512; beat data width.
REQ-003 Parameter EMPTY_W, default 6; empty-field width.
REQ-004 Clk  input  1  single clock for all logic.
REQ-005 Rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  NUM_IN x DATA_W  per-requester beat data.
REQ-007 in_valid  input  NUM_IN  per-requester valid.
REQ-008 in_ready  output  NUM_IN  per-requester ready.
REQ-009 in_sop  input  NUM_IN  per-requester start of packet.
REQ-010 in_eop  input  NUM_IN  per-requester end of packet.
REQ-011 in_empty  input  NUM_IN x EMPTY_W  per-requester empty count.
REQ-012 out_data/out_valid/out_sop/out_eop/out_empty  output  DATA_W/1/1/1/EMPTY_W  merged stream to the downstream packet FIFO.
REQ-013 out_ready  input  1  downstream ready.
REQ-014 out_almost_full  input  1  downstream almost-full; blocks new packet grants only.
REQ-015 cur_grant  output  clog2(NUM_IN)  index of the current or last granted requester.
REQ-016 drop_cnt  output  32  count of discarded orphan beats.

Function
REQ-017 States: IDLE (no grant) and XFER (grant held on one requester).
REQ-018 Request i = in_valid[i] & in_sop[i]; arbitration in IDLE only, and only when out_almost_full=0.
REQ-019 Round-robin: search starts at (last_grant+1) mod NUM_IN; first requester found wins.
REQ-020 Grant registered: IDLE->XFER on the cycle after arbitration; one-cycle bubble per packet.
REQ-021 In XFER, out_* = granted in_* combinationally, in_ready[g] = out_ready, other in_ready = 0.
REQ-022 Beat accepted when out_valid & out_ready; eop accepted -> IDLE next cycle, last_grant <= g.
REQ-023 A single-beat packet (sop & eop) takes one XFER cycle.
REQ-024 out_almost_full is ignored while in XFER; a packet in progress is never stalled by it.
REQ-025 In IDLE, any in_valid[i]=1 with in_sop[i]=0 is an orphan: in_ready[i]=1, beat discarded, drop_cnt += number of orphans that cycle.
REQ-026 drop_cnt saturates at 2^32-1.
REQ-027 In IDLE, out_valid=0 and in_ready=0 for all non-orphan inputs.
REQ-028 A sop arriving mid-packet on the granted input passes through unchanged; it is not checked.

Reset
REQ-029 Reset forces IDLE; out_valid=0, in_ready=0, cur_grant=NUM_IN-1 (so requester 0 wins first), drop_cnt=0.
REQ-030 Reset during XFER abandons the packet; no eop is generated.

Configuration
REQ-031 With PKT_ARB_STATS_EN defined, the block adds output pkt_cnt (NUM_IN x 32), one counter per requester, incremented on each accepted eop and saturating; reset value 0.
REQ-032 Without PKT_ARB_STATS_EN, the pkt_cnt port and its logic are absent.

Structure
REQ-033 The state enum (IDLE, XFER) and the counter width constant (32) go in the shared struct package.
REQ-034 The round-robin priority search is one sub-module, rr_pick, which is combinational and takes the request vector and last_grant and returns a valid flag and an index.

Verification
REQ-035 After reset, requesters 0 and 2 each present a 3-beat packet -> requester 0 is transferred first, then requester 2, with one bubble between them and cur_grant 0 then 2.
REQ-036 All 4 requesters continuously present single-beat packets -> grant order 0,1,2,3,0, with one output beat every 2 cycles.
REQ-037 out_almost_full=1 while in IDLE with requests pending -> no grant; after deassertion, a grant appears 1 cycle later.
REQ-038 out_almost_full rises mid-packet, and out_ready toggles 1,0,1 -> the packet completes with data intact and no beat duplicated or lost.
REQ-039 Requester 1 sends 2 beats without sop while IDLE -> both beats are consumed and drop_cnt=2.
REQ-040 Rst_n is asserted during beat 2 of a 4-beat packet -> out_valid=0 immediately; after release, requester 0 wins first.
